// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - writeback scheduler for a single-write-port register file
//
// Arbitrates between the execute-stage writer (EX) and the load/store-unit writer
// (LSU), registers the winning write onto the register file port, tracks
// outstanding loads in a pending scoreboard and flags decode read hazards.
//
// Optional feature macro: REGFILE_WB_RR_EN
//   defined   : round-robin between EX and LSU when both are eligible
//   undefined : fixed LSU priority (EX may starve while lsu_valid is held)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid/ex_ready           EX write handshake, ex_rd/ex_data payload
//   lsu_issue, lsu_issue_rd     load issued, marks destination pending
//   lsu_valid/lsu_ready         LSU write handshake, lsu_rd/lsu_data payload
//   rs1_addr, rs2_addr          decode source registers
//   rs_hazard                   decode must stall
//   rf_rd_addr, rf_rd_data      registered register file write port (addr 0 = idle)
module regfile_wb_sched #(
    parameter int EMBEDDED = 1,
    localparam int RA_W = (EMBEDDED != 0) ? 4 : 5,
    localparam int NREG = 1 << RA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [31:0]     ex_data,
    input  logic            lsu_issue,
    input  logic [RA_W-1:0] lsu_issue_rd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RA_W-1:0] lsu_rd,
    input  logic [31:0]     lsu_data,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    output logic            rs_hazard,
    output logic [RA_W-1:0] rf_rd_addr,
    output logic [31:0]     rf_rd_data
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic            grant_ex;
    logic            grant_lsu;
    logic            haz1;
    logic            haz2;

`ifdef REGFILE_WB_RR_EN
    // rr_last: 0 = EX accepted last, 1 = LSU accepted last
    logic rr_last;
    logic ex_elig;

    always_comb begin
        // EX blocked by a pending load to its rd is not eligible, so it never
        // steals a turn it cannot use.
        ex_elig   = ex_valid & ~pending[ex_rd];
        grant_ex  = 1'b0;
        grant_lsu = 1'b0;
        if (ex_elig && lsu_valid) begin
            grant_ex  = rr_last;
            grant_lsu = ~rr_last;
        end else begin
            grant_ex  = ex_elig;
            grant_lsu = lsu_valid;
        end
    end
`else
    always_comb begin
        grant_lsu = 1'b1;
        grant_ex  = ~lsu_valid;
    end
`endif

    // Holding EX while its rd is pending prevents an older load from
    // overwriting a younger EX result (WAW).
    assign lsu_ready = lsu_valid & grant_lsu;
    assign ex_ready  = ex_valid & grant_ex & ~pending[ex_rd];

    // The write currently on the port is still in flight for one edge, so it
    // counts as a hazard alongside the pending loads.
    assign haz1      = (rs1_addr != '0) && (pending[rs1_addr] || (rs1_addr == rf_rd_addr));
    assign haz2      = (rs2_addr != '0) && (pending[rs2_addr] || (rs2_addr == rf_rd_addr));
    assign rs_hazard = haz1 | haz2;

    always_comb begin
        pending_nxt = pending;
        if (lsu_ready) begin
            pending_nxt[lsu_rd] = 1'b0;
        end
        // Set is applied after clear so an issue to the same register wins.
        if (lsu_issue) begin
            pending_nxt[lsu_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            pending    <= '0;
`ifdef REGFILE_WB_RR_EN
            rr_last    <= 1'b0;
`endif
        end else begin
            pending <= pending_nxt;
            if (lsu_ready) begin
                rf_rd_addr <= lsu_rd;
                rf_rd_data <= lsu_data;
            end else if (ex_ready) begin
                rf_rd_addr <= ex_rd;
                rf_rd_data <= ex_data;
            end else begin
                rf_rd_addr <= '0;
            end
`ifdef REGFILE_WB_RR_EN
            if (lsu_ready) begin
                rr_last <= 1'b1;
            end else if (ex_ready) begin
                rr_last <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - scoreboard bench for regfile_wb_sched
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_rd;
    logic [31:0] ex_data;
    logic        lsu_issue;
    logic [3:0]  lsu_issue_rd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic        rs_hazard;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;

    int checks = 0;
    int errors = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    regfile_wb_sched #(.EMBEDDED(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .lsu_issue    (lsu_issue),
        .lsu_issue_rd (lsu_issue_rd),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs_hazard    (rs_hazard),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Write port monitor: every non-idle write must match the next expected one.
    always @(negedge clk) begin
        if (mon_en && rf_rd_addr != 4'd0) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         rf_rd_addr, rf_rd_data);
            end else begin
                logic [3:0]  ea;
                logic [31:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (rf_rd_addr !== ea || rf_rd_data !== ed) begin
                    errors++;
                    $display("FAIL write_port: got addr %0d data %0h expected addr %0d data %0h",
                             rf_rd_addr, rf_rd_data, ea, ed);
                end
            end
        end
    end

    task automatic idle();
        ex_valid     = 1'b0;
        ex_rd        = 4'd0;
        ex_data      = 32'd0;
        lsu_issue    = 1'b0;
        lsu_issue_rd = 4'd0;
        lsu_valid    = 1'b0;
        lsu_rd       = 4'd0;
        lsu_data     = 32'd0;
        rs1_addr     = 4'd0;
        rs2_addr     = 4'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        rs1_addr = 4'd1;
        rs2_addr = 4'd2;
        @(negedge clk);
        chk("reset_rf_addr", 32'(rf_rd_addr), 32'd0);
        chk("reset_rf_data", rf_rd_data, 32'd0);
        chk("reset_hazard", 32'(rs_hazard), 32'd0);

        // Test 1: simple EX write, in-flight hazard
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd5; ex_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_ex_ready", 32'(ex_ready), 32'd1);
        chk("t1_lsu_ready", 32'(lsu_ready), 32'd0);
        expect_write(4'd5, 32'hDEADBEEF);
        next_cycle();
        rs1_addr = 4'd5;
        @(negedge clk);
        chk("t1_hazard_inflight", 32'(rs_hazard), 32'd1);
        next_cycle();
        rs1_addr = 4'd5;
        @(negedge clk);
        chk("t1_hazard_cleared", 32'(rs_hazard), 32'd0);

        // Test 2: load pending hazard
        next_cycle();
        lsu_issue = 1'b1; lsu_issue_rd = 4'd3;
        next_cycle();
        rs2_addr = 4'd3;
        @(negedge clk);
        chk("t2_hazard_pending_a", 32'(rs_hazard), 32'd1);
        next_cycle();
        rs2_addr = 4'd3;
        @(negedge clk);
        chk("t2_hazard_pending_b", 32'(rs_hazard), 32'd1);
        next_cycle();
        rs2_addr = 4'd3;
        lsu_valid = 1'b1; lsu_rd = 4'd3; lsu_data = 32'h1234;
        @(negedge clk);
        chk("t2_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t2_hazard_accept", 32'(rs_hazard), 32'd1);
        expect_write(4'd3, 32'h1234);
        next_cycle();
        rs2_addr = 4'd3;
        @(negedge clk);
        chk("t2_hazard_inflight", 32'(rs_hazard), 32'd1);
        next_cycle();
        rs2_addr = 4'd3;
        @(negedge clk);
        chk("t2_hazard_done", 32'(rs_hazard), 32'd0);

        // Test 3: simultaneous EX rd6 and LSU rd7 (last accept was LSU)
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd6; ex_data = 32'h66;
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 32'h77;
        @(negedge clk);
`ifdef REGFILE_WB_RR_EN
        chk("t3_rr_ex_first", 32'(ex_ready), 32'd1);
        chk("t3_rr_lsu_wait", 32'(lsu_ready), 32'd0);
        expect_write(4'd6, 32'h66);
        next_cycle();
        lsu_valid = 1'b1; lsu_rd = 4'd7; lsu_data = 32'h77;
        @(negedge clk);
        chk("t3_rr_lsu_next", 32'(lsu_ready), 32'd1);
        expect_write(4'd7, 32'h77);
`else
        chk("t3_fix_lsu_first", 32'(lsu_ready), 32'd1);
        chk("t3_fix_ex_wait", 32'(ex_ready), 32'd0);
        expect_write(4'd7, 32'h77);
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd6; ex_data = 32'h66;
        @(negedge clk);
        chk("t3_fix_ex_next", 32'(ex_ready), 32'd1);
        expect_write(4'd6, 32'h66);
`endif

        // Test 4: WAW hold of EX behind a pending load
        next_cycle();
        lsu_issue = 1'b1; lsu_issue_rd = 4'd4;
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd4; ex_data = 32'h44;
        @(negedge clk);
        chk("t4_ex_held_a", 32'(ex_ready), 32'd0);
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd4; ex_data = 32'h44;
        @(negedge clk);
        chk("t4_ex_held_b", 32'(ex_ready), 32'd0);
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd4; ex_data = 32'h44;
        lsu_valid = 1'b1; lsu_rd = 4'd4; lsu_data = 32'h4444;
        @(negedge clk);
        chk("t4_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t4_ex_held_c", 32'(ex_ready), 32'd0);
        expect_write(4'd4, 32'h4444);
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd4; ex_data = 32'h44;
        @(negedge clk);
        chk("t4_ex_release", 32'(ex_ready), 32'd1);
        expect_write(4'd4, 32'h44);

        // Test 5: write to x0
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd0; ex_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t5_ex_ready", 32'(ex_ready), 32'd1);
        chk("t5_hazard_x0", 32'(rs_hazard), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t5_rf_addr_zero", 32'(rf_rd_addr), 32'd0);
        chk("t5_hazard_after", 32'(rs_hazard), 32'd0);

        // Test 6: reset with pending[2] and a write granted in the same cycle
        next_cycle();
        lsu_issue = 1'b1; lsu_issue_rd = 4'd2;
        next_cycle();
        ex_valid = 1'b1; ex_rd = 4'd9; ex_data = 32'h99;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        rs1_addr = 4'd2;
        rs2_addr = 4'd9;
        @(negedge clk);
        chk("t6_rf_addr_reset", 32'(rf_rd_addr), 32'd0);
        chk("t6_hazard_reset", 32'(rs_hazard), 32'd0);

        repeat (3) next_cycle();
        @(negedge clk);
        chk("queue_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
